fp_comp_pipe: RTL and testbench

Parametrised, pipelined IEEE-754 comparator and min/max unit for the simple FPU. It accepts two operands and an opcode under a valid/ready handshake and returns a predicate, relation flags, a min/max result and an invalid flag two cycles later. It handles NaN, ±0 and ±inf per IEEE 754-2008. It replaces the single-precision single-cycle comparator in the FPU execute stage, and any format is selected by parameters.

---
 rtl/fp_comp_pipe.sv | 157 +++++++++++++++
 tb/tb_fp_comp_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_comp_pipe.sv
// Two-stage IEEE-754 comparator and minNum/maxNum unit with valid/ready handshake.
// Stage 1 captures the operands and classifies them; stage 2 resolves the relation and result.
module fp_comp_pipe #(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int W  = EW + MW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [2:0]   op,
  input  logic         act,
  output logic         in_ready,
  input  logic         out_ready,
  output logic         done,
  output logic         flag,
  output logic         less,
  output logic         eq,
  output logic         great,
  output logic         unord,
  output logic [W-1:0] res,
  output logic         inv
);

  localparam logic [2:0] OP_EQ    = 3'd0;
  localparam logic [2:0] OP_LT    = 3'd1;
  localparam logic [2:0] OP_LE    = 3'd2;
  localparam logic [2:0] OP_MIN   = 3'd3;
  localparam logic [2:0] OP_MAX   = 3'd4;
  localparam logic [2:0] OP_UNORD = 3'd5;

  localparam logic [W-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MW]) && (|x[MW-1:0]);
  endfunction

  function automatic logic is_snan(input logic [W-1:0] x);
    return is_nan(x) && !x[MW-1];
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    return ~|x[W-2:0];
  endfunction

  logic         w_stall;
  logic         r_vld_p1, r_vld_p2;
  logic [W-1:0] r_a_p1, r_b_p1;
  logic [2:0]   r_op_p1;
  logic         r_nan_a_p1, r_nan_b_p1, r_snan_a_p1, r_snan_b_p1, r_zero_a_p1, r_zero_b_p1;

  assign w_stall  = r_vld_p2 & ~out_ready;
  assign in_ready = ~w_stall;
  assign done     = r_vld_p2;

  // ---- stage 1: capture and classify ----
  always_ff @(posedge clk) begin
    if (!w_stall && act) begin
      r_a_p1      <= in1;
      r_b_p1      <= in2;
      r_op_p1     <= op;
      r_nan_a_p1  <= is_nan(in1);
      r_nan_b_p1  <= is_nan(in2);
      r_snan_a_p1 <= is_snan(in1);
      r_snan_b_p1 <= is_snan(in2);
      r_zero_a_p1 <= is_zero(in1);
      r_zero_b_p1 <= is_zero(in2);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_vld_p1 <= 1'b0;
    else if (!w_stall) r_vld_p1 <= act;
  end

  // ---- stage 2: relation, predicate, result ----
  logic         w_less, w_eq, w_great, w_unord, w_flag, w_inv;
  logic [W-1:0] w_res;
  logic [W-2:0] w_ka, w_kb;
  logic         w_sa, w_sb;

  assign w_ka = r_a_p1[W-2:0];
  assign w_kb = r_b_p1[W-2:0];
  assign w_sa = r_a_p1[W-1];
  assign w_sb = r_b_p1[W-1];

  always_comb begin
    w_less  = 1'b0;
    w_eq    = 1'b0;
    w_great = 1'b0;
    w_unord = r_nan_a_p1 | r_nan_b_p1;
    if (w_unord) begin
      w_less = 1'b0;
    end else if (r_zero_a_p1 && r_zero_b_p1) begin
      w_eq = 1'b1;
    end else if (w_sa != w_sb) begin
      w_less  = w_sa;
      w_great = w_sb;
    end else if (w_ka == w_kb) begin
      w_eq = 1'b1;
    end else if ((w_ka > w_kb) ^ w_sa) begin
      w_great = 1'b1;
    end else begin
      w_less = 1'b1;
    end
  end

  always_comb begin
    w_flag = 1'b0;
    w_inv  = r_snan_a_p1 | r_snan_b_p1;
    w_res  = '0;
    case (r_op_p1)
      OP_EQ:    w_flag = w_eq;
      OP_LT:    begin w_flag = w_less;         w_inv = w_inv | w_unord; end
      OP_LE:    begin w_flag = w_less | w_eq;  w_inv = w_inv | w_unord; end
      OP_UNORD: w_flag = w_unord;
      OP_MIN, OP_MAX: begin
        if (r_nan_a_p1 && r_nan_b_p1)           w_res = QNAN;
        else if (r_nan_a_p1)                    w_res = r_b_p1;
        else if (r_nan_b_p1)                    w_res = r_a_p1;
        else if (r_zero_a_p1 && r_zero_b_p1)
          // signed zeros: MIN prefers -0, MAX prefers +0
          w_res = (r_op_p1 == OP_MIN) ? (w_sa ? r_a_p1 : r_b_p1) : (w_sa ? r_b_p1 : r_a_p1);
        else if (w_eq)                          w_res = r_a_p1;
        else if (r_op_p1 == OP_MIN)             w_res = w_less  ? r_a_p1 : r_b_p1;
        else                                    w_res = w_great ? r_a_p1 : r_b_p1;
      end
      default:  w_inv = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p2 <= 1'b0;
      flag     <= 1'b0;
      less     <= 1'b0;
      eq       <= 1'b0;
      great    <= 1'b0;
      unord    <= 1'b0;
      inv      <= 1'b0;
      res      <= '0;
    end else if (!w_stall) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        flag  <= w_flag;
        less  <= w_less;
        eq    <= w_eq;
        great <= w_great;
        unord <= w_unord;
        inv   <= w_inv;
        res   <= w_res;
      end
    end
  end

endmodule

// File: tb/tb_fp_comp_pipe.sv
// Scoreboard bench for fp_comp_pipe: directed vectors with hand-computed results,
// plus a half-precision instance for the parametrised format.
module tb_fp_comp_pipe;

  localparam logic [2:0] EQ = 3'd0, LT = 3'd1, LE = 3'd2, MIN = 3'd3,
                         MAX = 3'd4, UNO = 3'd5, RSV = 3'd6;

  typedef struct packed {
    logic       flag, less, eq, great, unord, inv;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in1, in2, res;
  logic [2:0]  op;
  logic        act, in_ready, out_ready, done, flag, less, eq, great, unord, inv;

  logic [15:0] h_in1, h_in2, h_res;
  logic [2:0]  h_op;
  logic        h_act, h_in_ready, h_out_ready, h_done, h_flag, h_less, h_eq, h_great, h_unord, h_inv;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fp_comp_pipe u_dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .op(op), .act(act),
    .in_ready(in_ready), .out_ready(out_ready), .done(done), .flag(flag),
    .less(less), .eq(eq), .great(great), .unord(unord), .res(res), .inv(inv)
  );

  fp_comp_pipe #(.EW(5), .MW(10)) u_half (
    .clk(clk), .rst(rst), .in1(h_in1), .in2(h_in2), .op(h_op), .act(h_act),
    .in_ready(h_in_ready), .out_ready(h_out_ready), .done(h_done), .flag(h_flag),
    .less(h_less), .eq(h_eq), .great(h_great), .unord(h_unord), .res(h_res), .inv(h_inv)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  function automatic exp_t E(input logic [5:0] f, input logic [31:0] r);
    return {f, r};
  endfunction

  function automatic exp_t outs();
    return {flag, less, eq, great, unord, inv, res};
  endfunction

  // monitor: pops one expectation per output handshake
  initial begin
    forever begin
      @(negedge clk);
      if (done && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(outs()), 64'hDEAD);
        end else begin
          chk("result", 64'(outs()), 64'(q.pop_front()));
        end
      end
    end
  end

  // caller sits just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] o, input exp_t e);
    int n = 0;
    in1 = a; in2 = b; op = o; act = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    else q.push_back(e);
    @(posedge clk); #1;
    act = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  task automatic hsend(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                       input string nm, input logic [21:0] e);
    int n = 0;
    h_in1 = a; h_in2 = b; h_op = o; h_act = 1'b1;
    @(posedge clk); #1;
    h_act = 1'b0;
    @(negedge clk);
    while (!h_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {42'd0, h_flag, h_less, h_eq, h_great, h_unord, h_inv, h_res}, {42'd0, e});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t snap;
    bit   seen;
    rst = 1'b1; act = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0; op = '0;
    h_act = 1'b0; h_out_ready = 1'b1; h_in1 = '0; h_in2 = '0; h_op = '0;
    repeat (2) @(posedge clk); #1;
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_outputs", 64'(outs()), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // latency: done rises after the second edge counting the accepting edge
    send(32'h3F800000, 32'h40000000, LT, E(6'b110000, 32'h0));
    chk("latency_first_edge", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("latency_second_edge", 64'(done), 64'd1);

    send(32'h3F800000, 32'h40000000, MAX, E(6'b010000, 32'h40000000));
    send(32'h80000000, 32'h00000000, EQ,  E(6'b101000, 32'h0));
    send(32'h80000000, 32'h00000000, MIN, E(6'b001000, 32'h80000000));
    send(32'h80000000, 32'h00000000, MAX, E(6'b001000, 32'h00000000));
    send(32'h7FC00000, 32'h3F800000, EQ,  E(6'b000010, 32'h0));
    send(32'h7FC00000, 32'h3F800000, LT,  E(6'b000011, 32'h0));
    send(32'h7F800001, 32'h3F800000, EQ,  E(6'b000011, 32'h0));
    send(32'h7FC00000, 32'h3F800000, MIN, E(6'b000010, 32'h3F800000));
    send(32'h7FC00001, 32'hFFC00000, MIN, E(6'b000010, 32'h7FC00000));
    send(32'hFF800000, 32'hC0000000, LE,  E(6'b110000, 32'h0));
    send(32'hBF800000, 32'hC0000000, EQ,  E(6'b000100, 32'h0));
    send(32'h7FC00000, 32'h00000000, UNO, E(6'b100010, 32'h0));
    send(32'h3F800000, 32'h40000000, RSV, E(6'b010001, 32'h0));
    send(32'hFF800000, 32'h3F800000, MAX, E(6'b010000, 32'h3F800000));
    send(32'h00000001, 32'h80000002, LT,  E(6'b000100, 32'h0));
    send(32'h40000000, 32'h40000000, MIN, E(6'b001000, 32'h40000000));
    wait_drain();

    // back-pressure: stall for three cycles after the first done
    @(posedge clk); #1;
    send(32'h3F800000, 32'h40000000, LT,  E(6'b110000, 32'h0));
    send(32'h80000000, 32'h00000000, MIN, E(6'b001000, 32'h80000000));
    out_ready = 1'b0;
    chk("bp_first_done", 64'(done), 64'd1);
    snap = outs();
    fork
      begin
        send(32'hFF800000, 32'hC0000000, LE,  E(6'b110000, 32'h0));
        send(32'h3F800000, 32'h40000000, RSV, E(6'b010001, 32'h0));
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_frozen", {25'd0, done, outs()}, {25'd0, 1'b1, snap});
          chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset with two operations in flight
    @(posedge clk); #1;
    send(32'h3F800000, 32'h40000000, LT,  E(6'b110000, 32'h0));
    send(32'h3F800000, 32'h40000000, MAX, E(6'b010000, 32'h40000000));
    chk("rst_pre_done", 64'(done), 64'd1);
    rst = 1'b1;
    #1;
    q.delete();
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_outputs", 64'(outs()), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("rst_no_stale_done", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // half-precision instance: {flag,less,eq,great,unord,inv,res}
    hsend(16'h3C00, 16'h4000, LT,  "half_lt",  {6'b110000, 16'h0000});
    hsend(16'h3C00, 16'h4000, MAX, "half_max", {6'b010000, 16'h4000});
    hsend(16'h7C01, 16'h3C00, EQ,  "half_snan", {6'b000011, 16'h0000});
    hsend(16'h7C01, 16'hFE00, MIN, "half_qnan", {6'b000011, 16'h7E00});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
